// File: rtl/clock_display.sv
// -----------------------------------------------------------------------------
// clock_display
//
// Display stage for the 24-hour clock. Turns the hour/minute/second fields into
// six decimal digits and scans them onto a six-digit common-anode seven-segment
// display, left to right HH MM SS. The field being edited blinks at 2 Hz.
//
// Parameters
//   CLK_FREQ_HZ  : clock frequency in Hz (>= 4); sets the blink timing.
//   DIGIT_CYCLES : clock cycles each digit stays lit (>= 1).
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   sec_in   in   [5:0] seconds field
//   min_in   in   [5:0] minutes field
//   hour_in  in   [4:0] hours field
//   select   in   [1:0] edit selection (SELECT_NONE/SEC/MIN/HOUR)
//   an       out  [5:0] digit enables, active-low; bit 0 = hour tens,
//                 bit 5 = seconds ones
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//
// Build option
//   CLOCK_DISPLAY_BLINK_EN : when defined, the blink generator and select
//   tracking are compiled in. When undefined, select is ignored and no digit
//   is ever blanked.
// -----------------------------------------------------------------------------

`ifndef KILO
`define KILO 1000
`endif
`ifndef SELECT_NONE
`define SELECT_NONE 2'd0
`endif
`ifndef SELECT_SEC
`define SELECT_SEC  2'd1
`endif
`ifndef SELECT_MIN
`define SELECT_MIN  2'd2
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd3
`endif

module clock_display #(
   parameter int CLK_FREQ_HZ  = `KILO,
   parameter int DIGIT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] sec_in,
   input  logic [5:0] min_in,
   input  logic [4:0] hour_in,
   input  logic [1:0] select,
   output logic [5:0] an,
   output logic [6:0] seg
);

   localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

   // load_q is high from reset until the first snapshot has been taken. The
   // scan is held during that edge so the first digit gets its full dwell.
   logic             load_q;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [4:0]       snap_hour;
   logic [5:0]       snap_min;
   logic [5:0]       snap_sec;
   logic             cnt_wrap;

   assign cnt_wrap = (cnt == CNT_MAX);

   // Scan counter and frame snapshot. The snapshot reloads on the edge that
   // moves idx from 5 back to 0, so every frame shows one coherent time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_q    <= 1'b1;
         cnt       <= '0;
         idx       <= 3'd0;
         snap_hour <= 5'd0;
         snap_min  <= 6'd0;
         snap_sec  <= 6'd0;
      end else if (load_q) begin
         load_q    <= 1'b0;
         snap_hour <= hour_in;
         snap_min  <= min_in;
         snap_sec  <= sec_in;
      end else if (cnt_wrap) begin
         cnt <= '0;
         if (idx == 3'd5) begin
            idx       <= 3'd0;
            snap_hour <= hour_in;
            snap_min  <= min_in;
            snap_sec  <= sec_in;
         end else begin
            idx <= idx + 3'd1;
         end
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Digit value: even idx shows the tens of its field, odd idx the ones.
   // Out-of-range inputs are shown as their plain decimal digits.
   logic [5:0] field_val;
   logic [5:0] digit;

   always_comb begin
      field_val = sec_snap_default();
      case (idx)
         3'd0, 3'd1: field_val = {1'b0, snap_hour};
         3'd2, 3'd3: field_val = snap_min;
         default:    field_val = snap_sec;
      endcase
      digit = idx[0] ? (field_val % 6'd10) : (field_val / 6'd10);
   end

   function automatic logic [5:0] sec_snap_default();
      return snap_sec;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [5:0] d);
      logic [6:0] p;
      case (d)
         6'd0:    p = 7'b1000000;
         6'd1:    p = 7'b1111001;
         6'd2:    p = 7'b0100100;
         6'd3:    p = 7'b0110000;
         6'd4:    p = 7'b0011001;
         6'd5:    p = 7'b0010010;
         6'd6:    p = 7'b0000010;
         6'd7:    p = 7'b1111000;
         6'd8:    p = 7'b0000000;
         6'd9:    p = 7'b0010000;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   logic blank;

`ifdef CLOCK_DISPLAY_BLINK_EN
   localparam int BQ   = CLK_FREQ_HZ / 4;
   localparam int BC_W = (BQ > 1) ? $clog2(BQ) : 1;
   localparam logic [BC_W-1:0] BCNT_MAX = BC_W'(BQ - 1);

   logic [BC_W-1:0] bcnt;
   logic            phase_blank;
   logic [1:0]      sel_prev;
   logic            field_hit;

   // Blink generator: phase toggles every CLK_FREQ_HZ/4 cycles. Any change
   // of select restarts it in the visible phase so an edit shows at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcnt        <= '0;
         phase_blank <= 1'b0;
         sel_prev    <= `SELECT_NONE;
      end else begin
         sel_prev <= select;
         if (select != sel_prev) begin
            bcnt        <= '0;
            phase_blank <= 1'b0;
         end else if (bcnt == BCNT_MAX) begin
            bcnt        <= '0;
            phase_blank <= ~phase_blank;
         end else begin
            bcnt <= bcnt + BC_W'(1);
         end
      end
   end

   always_comb begin
      field_hit = 1'b0;
      case (select)
         `SELECT_HOUR: field_hit = (idx == 3'd0) || (idx == 3'd1);
         `SELECT_MIN:  field_hit = (idx == 3'd2) || (idx == 3'd3);
         `SELECT_SEC:  field_hit = (idx == 3'd4) || (idx == 3'd5);
         default:      field_hit = 1'b0;
      endcase
      blank = phase_blank && field_hit;
   end
`else
   logic unused_select;
   assign unused_select = ^select;
   assign blank = 1'b0;
`endif

   // Output register: an and seg always load together. Nothing is lit on the
   // snapshot-load edge because the snapshot is not valid yet.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an  <= 6'b111111;
         seg <= 7'b1111111;
      end else if (load_q || blank) begin
         an  <= 6'b111111;
         seg <= 7'b1111111;
      end else begin
         an  <= ~(6'd1 << idx);
         seg <= seg_decode(digit);
      end
   end

endmodule

// File: tb/tb_clock_display.sv
`ifndef SELECT_NONE
`define SELECT_NONE 2'd0
`endif
`ifndef SELECT_SEC
`define SELECT_SEC  2'd1
`endif
`ifndef SELECT_MIN
`define SELECT_MIN  2'd2
`endif
`ifndef SELECT_HOUR
`define SELECT_HOUR 2'd3
`endif

module tb_clock_display;

   localparam int DC   = 2;
   localparam int FREQ = 8;
   localparam int HALF = FREQ / 4;

   logic       clk;
   logic       reset_n;
   logic [5:0] sec_in;
   logic [5:0] min_in;
   logic [4:0] hour_in;
   logic [1:0] select;
   logic [5:0] an;
   logic [6:0] seg;

   int checks;
   int errors;

   clock_display #(.CLK_FREQ_HZ(FREQ), .DIGIT_CYCLES(DC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sec_in  (sec_in),
      .min_in  (min_in),
      .hour_in (hour_in),
      .select  (select),
      .an      (an),
      .seg     (seg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] p;
      case (d)
         0: p = 7'b1000000;
         1: p = 7'b1111001;
         2: p = 7'b0100100;
         3: p = 7'b0110000;
         4: p = 7'b0011001;
         5: p = 7'b0010010;
         6: p = 7'b0000010;
         7: p = 7'b1111000;
         8: p = 7'b0000000;
         9: p = 7'b0010000;
         default: p = 7'b1111111;
      endcase
      return p;
   endfunction

   function automatic logic [5:0] an_of(input int i);
      logic [5:0] one;
      one = 6'd1;
      return ~(one << i);
   endfunction

   // Output after edge n (n >= 2, counted from reset release) shows this idx.
   function automatic int idx_at(input int n);
      return ((n - 2) / DC) % 6;
   endfunction

   // driver: hold reset, apply inputs, release on a falling edge
   task automatic start(input int h, input int m, input int s, input logic [1:0] sel);
      reset_n = 1'b0;
      hour_in = 5'(h);
      min_in  = 6'(m);
      sec_in  = 6'(s);
      select  = sel;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic edge_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      hour_in = 5'd23;
      min_in  = 6'd45;
      sec_in  = 6'd7;
      select  = `SELECT_NONE;
      repeat (3) @(negedge clk);
      checks++;
      if (an !== 6'b111111) begin
         errors++;
         $display("FAIL reset_an: got %b want 111111", an);
      end
      checks++;
      if (seg !== 7'b1111111) begin
         errors++;
         $display("FAIL reset_seg: got %b want 1111111", seg);
      end
      reset_n = 1'b1;
      edge_step();
      edge_step();
      checks++;
      if (an !== 6'b111110) begin
         errors++;
         $display("FAIL first_digit_an: got %b want 111110", an);
      end
      checks++;
      if (seg !== 7'b0100100) begin
         errors++;
         $display("FAIL first_digit_seg: got %b want 0100100", seg);
      end
   endtask

   task automatic test_full_frame();
      int d[6];
      int i;
      d = '{1, 2, 3, 4, 5, 6};
      start(12, 34, 56, `SELECT_NONE);
      for (int n = 1; n <= 13; n++) begin
         edge_step();
         if (n >= 2) begin
            i = idx_at(n);
            checks++;
            if (an !== an_of(i)) begin
               errors++;
               $display("FAIL frame_an n=%0d: got %b want %b", n, an, an_of(i));
            end
            checks++;
            if (seg !== seg_of(d[i])) begin
               errors++;
               $display("FAIL frame_seg n=%0d: got %b want %b", n, seg, seg_of(d[i]));
            end
         end
      end
   endtask

   task automatic test_snapshot_coherence();
      int d0[6];
      int d1[6];
      int i;
      int e;
      d0 = '{2, 3, 4, 5, 0, 7};
      d1 = '{2, 3, 4, 5, 0, 8};
      start(23, 45, 7, `SELECT_NONE);
      for (int n = 1; n <= 25; n++) begin
         edge_step();
         if (n >= 2) begin
            i = idx_at(n);
            e = (n <= 13) ? d0[i] : d1[i];
            checks++;
            if (an !== an_of(i) || seg !== seg_of(e)) begin
               errors++;
               $display("FAIL snapshot n=%0d: got an=%b seg=%b want an=%b seg=%b",
                        n, an, seg, an_of(i), seg_of(e));
            end
         end
         // idx is 2 here: the change must not tear the current frame
         if (n == 6) sec_in = 6'd8;
      end
   endtask

   task automatic test_out_of_range();
      int d[6];
      int i;
      d = '{0, 9, 0, 5, 6, 2};
      start(9, 5, 62, `SELECT_NONE);
      for (int n = 1; n <= 13; n++) begin
         edge_step();
         if (n >= 2) begin
            i = idx_at(n);
            checks++;
            if (an !== an_of(i) || seg !== seg_of(d[i])) begin
               errors++;
               $display("FAIL out_of_range n=%0d: got an=%b seg=%b want an=%b seg=%b",
                        n, an, seg, an_of(i), seg_of(d[i]));
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      start(12, 34, 56, `SELECT_NONE);
      repeat (7) edge_step();
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (an !== 6'b111111 || seg !== 7'b1111111) begin
         errors++;
         $display("FAIL mid_reset: got an=%b seg=%b want 111111 1111111", an, seg);
      end
      hour_in = 5'd23;
      min_in  = 6'd45;
      sec_in  = 6'd7;
      @(negedge clk);
      reset_n = 1'b1;
      edge_step();
      edge_step();
      checks++;
      if (an !== 6'b111110 || seg !== 7'b0100100) begin
         errors++;
         $display("FAIL mid_reset_restart: got an=%b seg=%b want 111110 0100100", an, seg);
      end
   endtask

`ifdef CLOCK_DISPLAY_BLINK_EN
   task automatic test_blink();
      int d[6];
      int i;
      int e_last;
      logic [1:0] cur;
      logic hit;
      logic bl;
      logic [5:0] exp_an;
      logic [6:0] exp_seg;
      d = '{1, 2, 3, 4, 5, 6};
      e_last = 0;
      cur = `SELECT_NONE;
      start(12, 34, 56, `SELECT_NONE);
      for (int n = 1; n <= 60; n++) begin
         edge_step();
         if (n >= 2 && n != e_last) begin
            i = idx_at(n);
            hit = (cur == `SELECT_HOUR && i <= 1) ||
                  (cur == `SELECT_MIN && (i == 2 || i == 3)) ||
                  (cur == `SELECT_SEC && i >= 4);
            bl = hit && (e_last > 0) && (n > e_last) &&
                 ((((n - e_last - 1) / HALF) % 2) == 1);
            exp_an  = bl ? 6'b111111 : an_of(i);
            exp_seg = bl ? 7'b1111111 : seg_of(d[i]);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
               errors++;
               $display("FAIL blink n=%0d sel=%0d: got an=%b seg=%b want an=%b seg=%b",
                        n, cur, an, seg, exp_an, exp_seg);
            end
         end
         if (n == 20) begin
            select = `SELECT_MIN;
            cur    = `SELECT_MIN;
            e_last = 21;
         end
         // phase is blank after edge 39; the switch lands on edge 40
         if (n == 39) begin
            select = `SELECT_HOUR;
            cur    = `SELECT_HOUR;
            e_last = 40;
         end
      end
   endtask
`else
   task automatic test_macro_off();
      int d[6];
      int i;
      d = '{1, 2, 3, 4, 5, 6};
      start(12, 34, 56, `SELECT_SEC);
      for (int n = 1; n <= 101; n++) begin
         edge_step();
         if (n >= 2) begin
            i = idx_at(n);
            checks++;
            if (an !== an_of(i) || seg !== seg_of(d[i])) begin
               errors++;
               $display("FAIL no_blink n=%0d: got an=%b seg=%b want an=%b seg=%b",
                        n, an, seg, an_of(i), seg_of(d[i]));
            end
         end
      end
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      hour_in = 5'd0;
      min_in  = 6'd0;
      sec_in  = 6'd0;
      select  = `SELECT_NONE;
      test_reset();
      test_full_frame();
      test_snapshot_coherence();
      test_out_of_range();
      test_reset_mid_frame();
`ifdef CLOCK_DISPLAY_BLINK_EN
      test_blink();
`else
      test_macro_off();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_display.md
# clock_display

Downstream display stage for the 24-hour clock. Consumes the clock's `sec_out`/`min_out`/`hour_out` and `select` values, converts each field to two decimal digits, and time-multiplexes them onto a six-digit common-anode seven-segment display, left to right as HH MM SS. The field selected for editing blinks at 2 Hz.

## Interface
- `CLK_FREQ_HZ`, default `` `KILO ``: clock frequency in Hz. Must be ≥4. Sets the blink timing.
- `DIGIT_CYCLES`, default 2: clock cycles each digit stays lit. Must be ≥1.
- `clk`  in  1  system clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sec_in`  in  6  seconds field, 0–59.
- `min_in`  in  6  minutes field, 0–59.
- `hour_in`  in  5  hours field, 0–23.
- `select`  in  2  edit selection, using `` `SELECT_NONE ``/`` `SELECT_SEC ``/`` `SELECT_MIN ``/`` `SELECT_HOUR `` from `constants.vh`.
- `an`  out  6  digit enables, active-low, one-hot-low. Bit 0 is hour tens; bit 5 is seconds ones.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.

## Operation
- **Scan counter**
  - `cnt` counts 0..DIGIT_CYCLES−1.
  - When it wraps, digit index `idx` advances 0→1→…→5→0.
- **Snapshot**
  - Registers capture `hour_in`/`min_in`/`sec_in` on the first clock edge after reset release.
  - They capture again on every edge where `idx`=5 and `cnt` wraps.
  - All six digits of one frame therefore come from one coherent time, with no tearing.
- **Digit value**
  - Tens digit = value/10; ones digit = value%10, computed from the snapshot.
  - Inputs above the legal range (for example sec 62) display as their decimal digits, with no clamping.
- **Segment encoding (active-low)**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- **Output stage**
  - `an` and `seg` are registered and always update on the same edge.
  - `an` = ~(1<<idx) and `seg` = the digit's pattern, unless the digit is blanked.
- **Blanking**
  - A blanked digit drives `an` bit high (all off) and `seg` = 1111111.
- **Blink generator**
  - `bcnt` counts 0..CLK_FREQ_HZ/4−1.
  - On wrap, phase toggles visible↔blank.
  - When phase is blank, the digits of the selected field are blanked: HOUR → idx 0,1; MIN → 2,3; SEC → 4,5. `` `SELECT_NONE `` blanks nothing.
  - Any change of `select` (compared with its value on the previous cycle) forces phase = visible and `bcnt` = 0 on that edge, so edits show immediately.

## Timing
- **Reset (async assert)**
  - `an` = 111111, `seg` = 1111111.
  - `idx` = 0, `cnt` = 0, `bcnt` = 0, phase = visible, snapshot = 0.
- **After reset release**
  - Edge 1: snapshot loads.
  - Edge 2: `an` = 111110, showing hour tens of the loaded value.
- **Latency**
  - `an`/`seg` reflect `idx` one cycle after `idx` changes.
  - Each digit is lit for exactly DIGIT_CYCLES cycles.
  - A full frame is 6·DIGIT_CYCLES cycles.
- **Input-change latency**
  - An input change is displayed starting at the next frame boundary.
  - Worst case is 6·DIGIT_CYCLES+1 cycles.
- **Blink**
  - Period CLK_FREQ_HZ/2 cycles, 50% duty.
  - The blank/visible decision is sampled when the output register loads, per digit.
- **Boundary cases**
  - A snapshot edge and a `select` change on the same edge are handled independently.
  - Reset mid-frame returns immediately to the reset values above; there is no partial-frame completion.

## Configuration
- `CLOCK_DISPLAY_BLINK_EN` defined: blink generator and `select` tracking are compiled in, and operate as above.
- Not defined: the blink logic is removed, `select` is ignored (the port is kept), and no digit is ever blanked.

## Test plan
- **Reset and first digit**
  - Stimulus: reset_n=0 with any inputs.
  - Required: `an`=111111 and `seg`=1111111.
  - Stimulus: release with hour 23, min 45, sec 07.
  - Required: at edge 2, `an`=111110 and `seg`=0100100 (digit "2").
- **Full frame** (DIGIT_CYCLES=2)
  - Stimulus: 12:34:56.
  - Required: `an` walks 111110→111101→…→011111, each held 2 cycles.
  - Required: `seg` shows 1,2,3,4,5,6.
- **Snapshot coherence**
  - Stimulus: change sec_in 07→08 while idx=2.
  - Required: the current frame's idx 4,5 still show 0,7.
  - Required: the next frame shows 0,8.
- **Blink** (define set, CLK_FREQ_HZ=8)
  - Stimulus: select=`` `SELECT_MIN ``.
  - Required: idx 2,3 are lit for 2 cycles, then blanked for 2 cycles, repeating.
  - Required: hour and sec digits are never blanked.
- **Select change resets phase**
  - Stimulus: switch `` `SELECT_MIN ``→`` `SELECT_HOUR `` during a blank phase.
  - Required: phase is visible on the next edge, and idx 0,1 are next blanked 2 cycles later.
- **Out-of-range and macro off**
  - Stimulus: sec_in=62.
  - Required: the seconds digits show "6","2".
  - Stimulus: macro undefined with select=`` `SELECT_SEC ``.
  - Required: no blanking over 100 cycles.
